cla_pipe_adder: RTL

- Two-stage pipelined carry-lookahead adder/subtractor built from per-bit generate/propagate/half-sum terms.
- Serves the integer EX path and the FPU mantissa/exponent adders; replaces ripple chains where timing fails.
- Stage 1 forms bit and 4-bit group g/p; stage 2 resolves group carries and produces sum and flags.
- Valid/ready handshake on both sides, with full-throughput backpressure.

---
 rtl/cla_pipe_adder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 registers per-bit generate/propagate/half-sum and 4-bit group G/P.
// Stage 2 resolves group carries, ripples inside each group, and registers
// sum, carry-out, signed overflow and zero. Valid/ready on both sides with
// full throughput and no skid buffer.

module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / 4;

    // Parameter legality is enforced at elaboration time.
    if (GROUP != 4) begin : g_bad_group
        $error("cla_pipe_adder: GROUP must be 4");
    end
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    // Stage-1 pipeline registers
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [NG-1:0]    gg_q, gg_d;
    logic [NG-1:0]    gp_q, gp_d;
    logic             c0_q, c0_d;
    logic             v1_q, v1_d;

    // Stage-2 (output) registers
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    // Combinational stage-1 terms
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] bit_g, bit_p, bit_h;
    logic [NG-1:0]    grp_g, grp_p;

    // Combinational stage-2 results
    logic [WIDTH-1:0] sum_w;
    logic             cout_w, ovf_w;

    logic adv2;

    // Handshake: output register moves when empty or drained; stage 1 accepts
    // when empty or when its content moves forward this cycle.
    assign adv2     = ~out_valid_q | out_ready;
    assign in_ready = ~v1_q | adv2;

    // Effective operand and per-bit / per-group generate-propagate terms.
    always_comb begin
        bb    = sub ? ~b : b;
        bit_g = a & bb;
        bit_p = a | bb;
        bit_h = a ^ bb;
        for (int k = 0; k < NG; k++) begin
            grp_g[k] = bit_g[4*k+3]
                     | (bit_p[4*k+3] & bit_g[4*k+2])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
            grp_p[k] = &bit_p[4*k +: 4];
        end
    end

    // Stage-1 next state: load on accept, drain to empty when idle, else hold.
    always_comb begin
        // NOTE: every variable gets a hold default first so no latch is inferred
        // on the paths that do not load.
        g_d  = g_q;
        p_d  = p_q;
        h_d  = h_q;
        gg_d = gg_q;
        gp_d = gp_q;
        c0_d = c0_q;
        v1_d = v1_q;
        if (in_ready) begin
            v1_d = in_valid;
            if (in_valid) begin
                g_d  = bit_g;
                p_d  = bit_p;
                h_d  = bit_h;
                gg_d = grp_g;
                gp_d = grp_p;
                c0_d = cin | sub;
            end
        end
    end

    // Stage-2 carry resolution and output-register next state.
    always_comb begin : stage2_comb
        logic [NG:0] grp_c;
        logic        c_run;
        logic        c_msb_in;

        grp_c[0] = c0_q;
        for (int k = 0; k < NG; k++) begin
            grp_c[k+1] = gg_q[k] | (gp_q[k] & grp_c[k]);
        end

        c_msb_in = 1'b0;
        for (int k = 0; k < NG; k++) begin
            c_run = grp_c[k];
            for (int j = 0; j < 4; j++) begin
                sum_w[4*k+j] = h_q[4*k+j] ^ c_run;
                c_msb_in     = c_run;
                c_run        = g_q[4*k+j] | (p_q[4*k+j] & c_run);
            end
        end
        cout_w = grp_c[NG];
        ovf_w  = grp_c[NG] ^ c_msb_in;

        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (adv2) begin
            if (v1_q) begin
                s_d         = sum_w;
                cout_d      = cout_w;
                ovf_d       = ovf_w;
                zero_d      = (sum_w == '0);
                out_valid_d = 1'b1;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge value of every other flop.
        if (rst) begin
            // NOTE: the data registers are cleared along with the valids so the
            // visible outputs are defined (zero) straight out of reset.
            g_q         <= '0;
            p_q         <= '0;
            h_q         <= '0;
            gg_q        <= '0;
            gp_q        <= '0;
            c0_q        <= 1'b0;
            v1_q        <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            g_q         <= g_d;
            p_q         <= p_d;
            h_q         <= h_d;
            gg_q        <= gg_d;
            gp_q        <= gp_d;
            c0_q        <= c0_d;
            v1_q        <= v1_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule
